alu_result_stage: RTL and testbench



---
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/alu_result_stage.sv | 89 ++++++++
 tb/tb_alu_result_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake and status bundle between the 4-bit adder/subtractor, the result
// stage and its consumer. The master modport belongs to the producer/consumer side.
interface alu_result_stage_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sum;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic             m;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       res;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             ovf_sticky;
    logic             clr_sticky;
    logic [CNT_W-1:0] res_count;

    modport master (
        output in_valid, sum, carry, a_msb, b_msb, m, out_ready, clr_sticky,
        input  in_ready, out_valid, res, flag_z, flag_n, flag_c, flag_v,
               ovf_sticky, res_count
    );

    modport slave (
        input  in_valid, sum, carry, a_msb, b_msb, m, out_ready, clr_sticky,
        output in_ready, out_valid, res, flag_z, flag_n, flag_c, flag_v,
               ovf_sticky, res_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 4-bit adder/subtractor: flags computed at
// capture, two-entry buffer, sticky overflow and a wrapping delivered-result count.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    alu_result_stage_if.slave  bus
);

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } entry_t;

    entry_t           new_e;
    entry_t           head;
    entry_t           tail;
    logic [1:0]       occ;
    logic             push;
    logic             pop;
    logic             sticky;
    logic [CNT_W-1:0] count;

    always_comb begin
        new_e     = '0;
        new_e.res = bus.sum;
        new_e.c   = bus.carry;
        new_e.z   = (bus.sum == 4'd0);
        new_e.n   = bus.sum[3];
        // b_msb arrives before the subtract inversion, hence the flipped sign test
        if (bus.m)
            new_e.v = (bus.a_msb != bus.b_msb) && (bus.sum[3] != bus.a_msb);
        else
            new_e.v = (bus.a_msb == bus.b_msb) && (bus.sum[3] != bus.a_msb);
    end

    assign bus.in_ready  = (occ != 2'(DEPTH));
    assign bus.out_valid = (occ != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // head is the output register itself, so it holds its last value when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            occ    <= 2'd0;
            sticky <= 1'b0;
            count  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        head <= new_e;
                    else
                        tail <= new_e;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2)
                        head <= tail;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // push requires a free slot, so occupancy is exactly one here
                    head <= new_e;
                end
                default: ;
            endcase
            sticky <= (sticky && !bus.clr_sticky) || (push && new_e.v);
            if (pop)
                count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.res        = head.res;
    assign bus.flag_z     = head.z;
    assign bus.flag_n     = head.n;
    assign bus.flag_c     = head.c;
    assign bus.flag_v     = head.v;
    assign bus.ovf_sticky = sticky;
    assign bus.res_count  = count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of alu_result_stage against an operand-level
// reference model (signed arithmetic and a queue standing in for the buffer).
module tb_alu_result_stage;

    localparam int CNT_W = 8;

    typedef struct {
        int res;
        int z;
        int n;
        int c;
        int v;
    } ment_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_result_stage_if #(.CNT_W(CNT_W)) bus ();

    alu_result_stage #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    ment_t q[$];
    ment_t hd;
    int    m_sticky;
    int    m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hd       = '{0, 0, 0, 0, 0};
        m_sticky = 0;
        m_count  = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        check({tag, ".in_ready"},  32'(bus.in_ready),  (q.size() != 2) ? 32'd1 : 32'd0);
        check({tag, ".res"},       32'(bus.res),        32'(hd.res));
        check({tag, ".z"},         32'(bus.flag_z),     32'(hd.z));
        check({tag, ".n"},         32'(bus.flag_n),     32'(hd.n));
        check({tag, ".c"},         32'(bus.flag_c),     32'(hd.c));
        check({tag, ".v"},         32'(bus.flag_v),     32'(hd.v));
        check({tag, ".sticky"},    32'(bus.ovf_sticky), 32'(m_sticky));
        check({tag, ".count"},     32'(bus.res_count),  32'(m_count % (1 << CNT_W)));
    endtask

    // One clock: present an operation on operands a,b, advance, update model, check.
    task automatic step(input string tag, input int iv, input int a, input int b,
                        input int sub, input int ordy, input int clr);
        int    r, sa, sb, full;
        int    push, pop;
        ment_t e;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        if (sub != 0) begin
            r     = sa - sb;
            e.res = (a - b) & 15;
            e.c   = (a >= b) ? 1 : 0;
        end else begin
            r     = sa + sb;
            e.res = (a + b) & 15;
            e.c   = ((a + b) >= 16) ? 1 : 0;
        end
        e.z = (e.res == 0) ? 1 : 0;
        e.n = (e.res >= 8) ? 1 : 0;
        e.v = (r > 7 || r < -8) ? 1 : 0;

        bus.in_valid   = (iv != 0);
        bus.sum        = 4'(e.res);
        bus.carry      = (e.c != 0);
        bus.a_msb      = (a >= 8);
        bus.b_msb      = (b >= 8);
        bus.m          = (sub != 0);
        bus.out_ready  = (ordy != 0);
        bus.clr_sticky = (clr != 0);

        @(posedge clk);
        full = (q.size() == 2) ? 1 : 0;
        push = (iv != 0 && full == 0) ? 1 : 0;
        pop  = (q.size() != 0 && ordy != 0) ? 1 : 0;
        m_sticky = ((m_sticky != 0 && clr == 0) || (push != 0 && e.v != 0)) ? 1 : 0;
        if (pop != 0) begin
            void'(q.pop_front());
            m_count++;
        end
        if (push != 0) q.push_back(e);
        if (q.size() != 0) hd = q[0];
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int ordy, input int clr);
        step(tag, 0, 0, 0, 0, ordy, clr);
    endtask

    int base;

    initial begin
        bus.in_valid   = 1'b0;
        bus.sum        = 4'd0;
        bus.carry      = 1'b0;
        bus.a_msb      = 1'b0;
        bus.b_msb      = 1'b0;
        bus.m          = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        model_reset();

        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 7+1 signed add overflow
        step("add_ovf", 1, 7, 1, 0, 0, 0);
        check("add_ovf.res8", 32'(bus.res), 32'd8);
        idle("add_ovf_pop", 1, 0);

        // 5-5 zero with no borrow, then -8-1 subtract overflow
        step("sub_zero", 1, 5, 5, 1, 0, 0);
        check("sub_zero.z", 32'(bus.flag_z), 32'd1);
        step("sub_ovf", 1, 8, 1, 1, 0, 0);
        idle("sub_pop1", 1, 0);
        check("sub_ovf.v", 32'(bus.flag_v), 32'd1);
        idle("sub_pop2", 1, 0);

        // sticky: set wins over clear, then clear alone
        idle("clr_pre", 0, 1);
        step("sticky_set_wins", 1, 7, 1, 0, 1, 1);
        check("sticky_set_wins.val", 32'(bus.ovf_sticky), 32'd1);
        idle("sticky_clear", 1, 1);
        check("sticky_clear.val", 32'(bus.ovf_sticky), 32'd0);
        idle("drain", 1, 0);

        // backpressure: 3 and 6 accepted, 9 refused while full
        base = m_count;
        step("bp3", 1, 3, 0, 0, 0, 0);
        step("bp6", 1, 6, 0, 0, 0, 0);
        step("bp9_refused", 1, 9, 0, 0, 0, 0);
        check("bp.full_head", 32'(bus.res), 32'd3);
        step("bp_pop3", 1, 9, 0, 0, 1, 0);
        check("bp.head6", 32'(bus.res), 32'd6);
        step("bp_pop6_push9", 1, 9, 0, 0, 1, 0);
        check("bp.head9", 32'(bus.res), 32'd9);
        check("bp.count2", 32'(m_count - base), 32'(bus.res_count - CNT_W'(base)));
        idle("bp_pop9", 1, 0);

        // reset mid-stream with two entries held
        step("pre_rst1", 1, 2, 3, 0, 0, 0);
        step("pre_rst2", 1, 4, 1, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst = 1'b0;

        // streaming: one result per cycle
        base = m_count;
        for (int i = 0; i < 20; i++)
            step("stream", 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), 1, 0);
        idle("stream_drain", 1, 0);
        check("stream.count20", 32'(bus.res_count), 32'(base + 20));

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1 : 0);

        // counter wrap after exactly 256 pops from reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++)
            step("wrap", 1, i & 15, (i >> 4) & 15, i & 1, 1, 0);
        idle("wrap_last", 1, 0);
        check("wrap.count0", 32'(bus.res_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
